// File: rtl/decode_pkg.sv
// Shared types, opcode map and decode helper for the IF/ID decode stage.
package decode_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned CNT_W   = 16;

  localparam int unsigned OPC_LO = 12;
  localparam int unsigned RD_LO  = 8;
  localparam int unsigned RS1_LO = 4;
  localparam int unsigned RS2_LO = 0;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h6;
  localparam logic [OPC_W-1:0] OP_LD   = 4'h7;
  localparam logic [OPC_W-1:0] OP_ST   = 4'h8;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h9;
  localparam logic [OPC_W-1:0] OP_BEZ  = 4'hA;
  localparam logic [OPC_W-1:0] OP_ILB  = 4'hB;
  localparam logic [OPC_W-1:0] OP_ILC  = 4'hC;
  localparam logic [OPC_W-1:0] OP_ILD  = 4'hD;
  localparam logic [OPC_W-1:0] OP_ILE  = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_t;

  typedef struct packed {
    logic wr_en;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic illegal;
  } flags_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [INSTR_W-1:0] imm;
    flags_t             flags;
  } dec_t;

  function automatic dec_t decode(input fetch_t e);
    dec_t d;
    d.pc     = e.pc;
    d.opcode = e.instr[OPC_LO +: OPC_W];
    d.rd     = e.instr[RD_LO +: REG_W];
    d.rs1    = e.instr[RS1_LO +: REG_W];
    d.rs2    = e.instr[RS2_LO +: REG_W];
    d.imm    = {{(INSTR_W-IMM_W){e.instr[IMM_W-1]}}, e.instr[IMM_W-1:0]};
    d.flags  = '0;
    case (d.opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: d.flags.wr_en = 1'b1;
      OP_ADDI: begin
        d.flags.wr_en = 1'b1;
        d.rs1         = e.instr[RD_LO +: REG_W];
      end
      OP_LD: begin
        d.flags.wr_en   = 1'b1;
        d.flags.is_load = 1'b1;
      end
      OP_ST:  d.flags.is_store  = 1'b1;
      OP_JMP: d.flags.is_branch = 1'b1;
      OP_BEZ: begin
        d.flags.is_branch = 1'b1;
        d.rs1             = e.instr[RD_LO +: REG_W];
      end
      OP_ILB, OP_ILC, OP_ILD, OP_ILE: d.flags.illegal = 1'b1;
      OP_NOP, OP_HLT: d.flags = '0;
      default: d.flags = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready buffer: storage, pointers and occupancy count.
module skid_fifo2 #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !rst && !clear) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/decode_stage.sv
// IF/ID stage: buffers fetched instructions, decodes the head and issues it to execute.
module decode_stage
  import decode_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rs1,
  output logic [REG_W-1:0]   out_rs2,
  output logic [INSTR_W-1:0] out_imm,
  output logic               out_wr_en,
  output logic               out_is_load,
  output logic               out_is_store,
  output logic               out_is_branch,
  output logic               out_illegal,
  output logic               halted,
  output logic [CNT_W-1:0]   issue_count
);

  state_t     state, state_next;
  logic [1:0] count;
  fetch_t     wdata, head_raw, head;
  dec_t       dec;
  logic       run, push, pop, issue, clear;

  assign run       = (state == ST_RUN);
  assign in_ready  = (count < 2'(DEPTH)) && run;
  assign out_valid = (count != 2'd0) && run;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign issue     = pop && !flush;
  // HALT drains the buffer every cycle, which also makes flush a no-op there.
  assign clear     = flush || !run;

  assign wdata.pc    = in_pc;
  assign wdata.instr = in_instr;

  skid_fifo2 #(.W($bits(fetch_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (issue),
    .wdata (wdata),
    .head  (head_raw),
    .count (count)
  );

  // An empty buffer presents an all-zero entry so decode shows a clean NOP.
  assign head = (count != 2'd0) ? head_raw : '0;
  assign dec  = decode(head);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (run && issue && (dec.opcode == OP_HLT)) state_next = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst)        issue_count <= '0;
    else if (issue) issue_count <= issue_count + CNT_W'(1);
  end

  assign halted        = !run;
  assign out_pc        = dec.pc;
  assign out_opcode    = dec.opcode;
  assign out_rd        = dec.rd;
  assign out_rs1       = dec.rs1;
  assign out_rs2       = dec.rs2;
  assign out_imm       = dec.imm;
  assign out_wr_en     = dec.flags.wr_en;
  assign out_is_load   = dec.flags.is_load;
  assign out_is_store  = dec.flags.is_store;
  assign out_is_branch = dec.flags.is_branch;
  assign out_illegal   = dec.flags.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- IF/ID boundary of the RISC core. Accepts (pc, instruction) pairs from the fetch stage and buffers them in a 2-entry skid FIFO.
- Decodes the head entry into register indices, a sign-extended immediate and control flags, then issues it to execute over a valid/ready handshake.
- Supports pipeline flush on branch redirect, and a HALT state entered when a HLT instruction issues.

Parameters:
- PC_W, 8, program-counter width
- INSTR_W, 16, instruction width
- DEPTH, 2, skid buffer entries (only 2 supported)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents pc/instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  8  pc of presented instruction
- in_instr  in  16  presented instruction
- flush  in  1  discard all buffered and presented instructions
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts
- out_pc  out  8  pc of issued instruction
- out_opcode  out  4  instr[15:12]
- out_rd  out  4  instr[11:8]
- out_rs1  out  4  instr[7:4] (ADDI/BEZ: instr[11:8])
- out_rs2  out  4  instr[3:0]
- out_imm  out  16  sign-extended instr[7:0]
- out_wr_en  out  1  writes rd
- out_is_load / out_is_store / out_is_branch  out  1 each  class flags
- out_illegal  out  1  undefined opcode
- halted  out  1  stage in HALT
- issue_count  out  16  issued-instruction counter

Behaviour:
- Reset (sync, rst=1 at posedge): FIFO empty, state RUN, issue_count=0, out_valid=0, halted=0, in_ready=1. All decoded outputs reflect a zero entry (NOP, flags 0).
- Push = in_valid & in_ready & !flush. Pop = out_valid & out_ready.
- in_ready = (count<2) & state==RUN. Registered-count based; no combinational path from out_ready.
- Latency: an entry pushed at edge N appears on out_* after edge N (visible in cycle N+1). Order is strictly FIFO.
- Simultaneous push+pop: count unchanged; head advances and the new entry is written at the tail. At count=2 no push occurs, and the pop frees a slot for the next cycle.
- out_valid = (count>0) & state==RUN. out_* are combinational decode of the head entry and hold stable while out_valid & !out_ready.
- Opcode map (package constants):
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: wr_en=1
  - 6 ADDI: wr_en=1, rs1=rd
  - 7 LD: wr_en=1, is_load
  - 8 ST: is_store
  - 9 JMP: is_branch
  - A BEZ: is_branch, rs1=instr[11:8]
  - B–E illegal: illegal=1, wr_en=0, other flags 0; still issued
  - F HLT
- Flush: at the edge, count←0 and any presented input is dropped. Flush has priority over push and pop. issue_count is not incremented by a pop in the same cycle.
- FSM:
  - RUN→HALT when a HLT entry pops.
  - HALT: out_valid=0, in_ready=0, halted=1, FIFO contents discarded (count←0). flush is ignored.
  - HALT exits only via rst.
- issue_count increments by 1 per pop (excluding a flush-cycle pop). It wraps 0xFFFF→0x0000. The HLT instruction itself is counted.
- Reset mid-operation: same as power-on reset. Buffered entries are lost.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams (OP_NOP…OP_HLT)
  - field bit positions
  - a decoded-instruction struct/typedef (pc, opcode, rd, rs1, rs2, imm, flags)
- Sub-module skid_fifo2 (2-entry valid/ready buffer, width-parameterised) holds storage/pointers.
- decode_stage holds the decode logic, FSM and counter.

Test Plan:
- Reset then push 0x1123@pc0 with out_ready=1 → next cycle out_valid=1, opcode=1, rd=1, rs1=2, rs2=3, wr_en=1, issue_count becomes 1 after pop.
- Backpressure: out_ready=0, push 0x6105, 0x7230, 0x0000 → third blocked (in_ready=0 after 2). Release → ADDI (imm=0x0005, rs1=1) then LD in order, then NOP accepted.
- Sign extension: push 0x61FE → out_imm=0xFFFE. Push 0xC000 → illegal=1, wr_en=0, still issued.
- Flush with 2 entries buffered and in_valid=1 → next cycle out_valid=0, count 0, presented instr not issued, issue_count unchanged.
- Push 0xF000 then 0x1111, out_ready=1 → after HLT pop halted=1, in_ready=0, 0x1111 never issued, flush no effect. rst → RUN, issue_count=0.
- Counter wrap: force 65536 pops → issue_count returns to 0x0000.
